ps2_keymatrix: RTL and testbench



---
 rtl/ps2_keymatrix.sv | 274 +++++++++++++++++++++++++++
 tb/tb_ps2_keymatrix.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_keymatrix.sv
// PS/2 keyboard front-end for the Lynx 48K: frame receiver, scancode decoder and 10x8 key matrix.
// Optional odd-parity rejection is compiled in with `define PS2_PARITY_CHECK_EN.
module ps2_keymatrix #(
  parameter logic [15:0] TIMEOUT = 16'd6000,
  parameter int unsigned FILT    = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] ps2,
  input  logic [3:0] row,
  output logic [7:0] col,
  output logic       boot,
  output logic       kreset
);

  localparam int unsigned FiltW = (FILT > 1) ? $clog2(FILT) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StParity,
    StStop,
    StDone
  } rx_state_e;

  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic             r_clk_f;
  logic [FiltW-1:0] r_filt_cnt;

  rx_state_e        r_state;
  logic [7:0]       r_shift;
  logic [2:0]       r_bitcnt;
  logic             r_parity;
  logic [15:0]      r_wd;
  logic [7:0]       r_byte;

  logic             r_rel;
  logic             r_ext;
  logic [9:0][7:0]  r_matrix;
  logic [7:0]       r_col;
  logic             r_boot;
  logic             r_kreset;

  logic             w_clk_s;
  logic             w_dat_s;
  logic             w_filt_full;
  logic             w_fall;
  logic             w_par_calc;
  logic             w_par_ok;
  logic             w_strobe;
  logic             w_hit;
  logic [3:0]       w_mrow;
  logic [2:0]       w_mcol;
  logic [7:0]       w_row_bits;

  assign w_clk_s = r_sync2[0];
  assign w_dat_s = r_sync2[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
    end else begin
      r_sync1 <= ps2;
      r_sync2 <= r_sync1;
    end
  end

  // The filtered level flips on the FILT-th consecutive ce sample that disagrees with it.
  assign w_filt_full = (r_filt_cnt == FiltW'(FILT - 1));
  assign w_fall      = ce && r_clk_f && !w_clk_s && w_filt_full;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_clk_f    <= 1'b1;
      r_filt_cnt <= '0;
    end else if (ce) begin
      if (w_clk_s == r_clk_f) begin
        r_filt_cnt <= '0;
      end else if (w_filt_full) begin
        r_clk_f    <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_par_calc = ^{r_shift, r_parity};
`ifdef PS2_PARITY_CHECK_EN
  assign w_par_ok = w_par_calc;
`else
  // Parity is captured for visibility but never gates the strobe in this build.
  assign w_par_ok = w_par_calc | 1'b1;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_parity <= 1'b0;
      r_wd     <= '0;
      r_byte   <= '0;
    end else if (r_state == StDone) begin
      r_state <= StIdle;
      r_wd    <= '0;
    end else if (w_fall) begin
      r_wd <= '0;
      case (r_state)
        StIdle: begin
          if (!w_dat_s) begin
            r_state  <= StData;
            r_bitcnt <= '0;
          end
        end
        StData: begin
          r_shift  <= {w_dat_s, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            r_state <= StParity;
          end
        end
        StParity: begin
          r_parity <= w_dat_s;
          r_state  <= StStop;
        end
        StStop: begin
          if (w_dat_s && w_par_ok) begin
            r_byte  <= r_shift;
            r_state <= StDone;
          end else begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end else if (ce && (r_state != StIdle)) begin
      if (r_wd == TIMEOUT - 16'd1) begin
        r_wd    <= '0;
        r_state <= StIdle;
      end else begin
        r_wd <= r_wd + 16'd1;
      end
    end
  end

  assign w_strobe = (r_state == StDone);

  // Lynx matrix position for {ext, scancode}.
  always_comb begin
    w_hit  = 1'b1;
    w_mrow = 4'd0;
    w_mcol = 3'd0;
    case ({r_ext, r_byte})
      9'h012, 9'h059: begin w_mrow = 4'd0; w_mcol = 3'd0; end
      9'h076:         begin w_mrow = 4'd0; w_mcol = 3'd1; end
      9'h172:         begin w_mrow = 4'd0; w_mcol = 3'd2; end
      9'h014, 9'h114: begin w_mrow = 4'd0; w_mcol = 3'd3; end
      9'h058:         begin w_mrow = 4'd0; w_mcol = 3'd4; end
      9'h016:         begin w_mrow = 4'd0; w_mcol = 3'd7; end
      9'h021:         begin w_mrow = 4'd1; w_mcol = 3'd0; end
      9'h023:         begin w_mrow = 4'd1; w_mcol = 3'd1; end
      9'h022:         begin w_mrow = 4'd1; w_mcol = 3'd2; end
      9'h024:         begin w_mrow = 4'd1; w_mcol = 3'd3; end
      9'h025:         begin w_mrow = 4'd1; w_mcol = 3'd4; end
      9'h026:         begin w_mrow = 4'd1; w_mcol = 3'd5; end
      9'h01E:         begin w_mrow = 4'd1; w_mcol = 3'd6; end
      9'h029:         begin w_mrow = 4'd1; w_mcol = 3'd7; end
      9'h01A:         begin w_mrow = 4'd2; w_mcol = 3'd0; end
      9'h01B:         begin w_mrow = 4'd2; w_mcol = 3'd1; end
      9'h01C:         begin w_mrow = 4'd2; w_mcol = 3'd2; end
      9'h01D:         begin w_mrow = 4'd2; w_mcol = 3'd3; end
      9'h015:         begin w_mrow = 4'd2; w_mcol = 3'd4; end
      9'h02D:         begin w_mrow = 4'd3; w_mcol = 3'd0; end
      9'h02B:         begin w_mrow = 4'd3; w_mcol = 3'd1; end
      9'h034:         begin w_mrow = 4'd3; w_mcol = 3'd2; end
      9'h02C:         begin w_mrow = 4'd3; w_mcol = 3'd3; end
      9'h02A:         begin w_mrow = 4'd3; w_mcol = 3'd4; end
      9'h02E:         begin w_mrow = 4'd3; w_mcol = 3'd5; end
      9'h036:         begin w_mrow = 4'd3; w_mcol = 3'd6; end
      9'h032:         begin w_mrow = 4'd4; w_mcol = 3'd0; end
      9'h031:         begin w_mrow = 4'd4; w_mcol = 3'd1; end
      9'h033:         begin w_mrow = 4'd4; w_mcol = 3'd2; end
      9'h035:         begin w_mrow = 4'd4; w_mcol = 3'd3; end
      9'h03D:         begin w_mrow = 4'd4; w_mcol = 3'd4; end
      9'h03B:         begin w_mrow = 4'd5; w_mcol = 3'd0; end
      9'h03A:         begin w_mrow = 4'd5; w_mcol = 3'd1; end
      9'h03C:         begin w_mrow = 4'd5; w_mcol = 3'd2; end
      9'h03E:         begin w_mrow = 4'd5; w_mcol = 3'd3; end
      9'h042:         begin w_mrow = 4'd6; w_mcol = 3'd0; end
      9'h041:         begin w_mrow = 4'd6; w_mcol = 3'd1; end
      9'h043:         begin w_mrow = 4'd6; w_mcol = 3'd2; end
      9'h046:         begin w_mrow = 4'd6; w_mcol = 3'd3; end
      9'h044:         begin w_mrow = 4'd6; w_mcol = 3'd4; end
      9'h04B:         begin w_mrow = 4'd7; w_mcol = 3'd0; end
      9'h049:         begin w_mrow = 4'd7; w_mcol = 3'd1; end
      9'h04D:         begin w_mrow = 4'd7; w_mcol = 3'd2; end
      9'h045:         begin w_mrow = 4'd7; w_mcol = 3'd3; end
      9'h04C:         begin w_mrow = 4'd7; w_mcol = 3'd4; end
      9'h04A:         begin w_mrow = 4'd8; w_mcol = 3'd0; end
      9'h052:         begin w_mrow = 4'd8; w_mcol = 3'd1; end
      9'h054:         begin w_mrow = 4'd8; w_mcol = 3'd2; end
      9'h05A, 9'h15A: begin w_mrow = 4'd8; w_mcol = 3'd3; end
      9'h04E:         begin w_mrow = 4'd8; w_mcol = 3'd4; end
      9'h066:         begin w_mrow = 4'd8; w_mcol = 3'd5; end
      9'h16B:         begin w_mrow = 4'd9; w_mcol = 3'd0; end
      9'h175:         begin w_mrow = 4'd9; w_mcol = 3'd1; end
      9'h174:         begin w_mrow = 4'd9; w_mcol = 3'd2; end
      9'h055:         begin w_mrow = 4'd9; w_mcol = 3'd3; end
      9'h05B:         begin w_mrow = 4'd9; w_mcol = 3'd4; end
      9'h05D:         begin w_mrow = 4'd9; w_mcol = 3'd5; end
      9'h171:         begin w_mrow = 4'd9; w_mcol = 3'd6; end
      default:        w_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rel    <= 1'b0;
      r_ext    <= 1'b0;
      r_matrix <= '0;
      r_boot   <= 1'b0;
      r_kreset <= 1'b0;
    end else begin
      r_boot <= 1'b0;
      if (w_strobe) begin
        case (r_byte)
          8'hF0: r_rel <= 1'b1;
          8'hE0: r_ext <= 1'b1;
          // Keyboard housekeeping bytes must not disturb a pending prefix.
          8'h00, 8'hAA, 8'hFC, 8'hFE, 8'hFF, 8'hE1: ;
          default: begin
            r_rel <= 1'b0;
            r_ext <= 1'b0;
            if (w_hit) begin
              r_matrix[w_mrow][w_mcol] <= !r_rel;
            end
            if (!r_ext && (r_byte == 8'h78)) begin
              r_kreset <= !r_rel;
            end
            if (!r_ext && !r_rel && (r_byte == 8'h07)) begin
              r_boot <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    w_row_bits = 8'h00;
    for (int i = 0; i < 10; i++) begin
      if (row == 4'(i)) begin
        w_row_bits = r_matrix[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_col <= 8'hFF;
    end else begin
      r_col <= ~w_row_bits;
    end
  end

  assign col    = r_col;
  assign boot   = r_boot;
  assign kreset = r_kreset;

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Scoreboard bench for ps2_keymatrix: directed PS/2 frames, expected column/kreset/boot
// tuples queued by the stimulus and checked by an independent negedge monitor.
module tb_ps2_keymatrix;

  localparam int Half = 20;

  logic       clock;
  logic       reset;
  logic       ce;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [1:0] ps2;
  logic [3:0] row;
  logic [7:0] col;
  logic       boot;
  logic       kreset;

  assign ps2 = {ps2_dat, ps2_clk};

  ps2_keymatrix dut (
    .clock  (clock),
    .reset  (reset),
    .ce     (ce),
    .ps2    (ps2),
    .row    (row),
    .col    (col),
    .boot   (boot),
    .kreset (kreset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    ce = 1'b0;
    forever begin
      @(negedge clock);
      ce = ~ce;
    end
  end

  typedef struct {
    string      name;
    logic [7:0] col;
    logic       kr;
    int         boots;
  } exp_t;

  exp_t exp_q[$];
  logic chk_req = 1'b0;
  int   n_cmp   = 0;
  int   n_fail  = 0;
  int   boot_w  = 0;
  int   boot_cnt = 0;
  int   exp_boots = 0;
  logic exp_k = 1'b0;

  // Monitor: boot pulse width/count, and scoreboard pops on each check request.
  always @(negedge clock) begin
    if (boot) begin
      if (boot_w == 0) boot_cnt++;
      boot_w++;
    end else if (boot_w != 0) begin
      n_cmp++;
      if (boot_w != 1) begin
        n_fail++;
        $display("FAIL boot_width: got %0d clocks, want 1", boot_w);
      end
      boot_w = 0;
    end
    if (chk_req) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL scoreboard: check requested with empty queue");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (col !== e.col || kreset !== e.kr || boot_cnt != e.boots) begin
          n_fail++;
          $display("FAIL %s: col=%h kreset=%b boots=%0d, want col=%h kreset=%b boots=%0d",
                   e.name, col, kreset, boot_cnt, e.col, e.kr, e.boots);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [3:0] r, input logic [7:0] c);
    @(negedge clock);
    row = r;
    repeat (3) @(negedge clock);
    #1;
    exp_q.push_back('{nm, c, exp_k, exp_boots});
    chk_req = 1'b1;
    @(negedge clock);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic ps2_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_dat = bits[i];
      repeat (Half) @(negedge clock);
      ps2_clk = 1'b0;
      repeat (Half) @(negedge clock);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input bit flip);
    logic p;
    p = ~(^b) ^ flip;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send(input logic [7:0] b);
    ps2_bits(frame(b, 1'b0), 11);
    repeat (40) @(negedge clock);
  endtask

  initial begin
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    row     = 4'd0;
    reset   = 1'b0;
    repeat (4) @(negedge clock);
    for (int r = 0; r < 16; r++) begin
      check($sformatf("reset_row%0d", r), 4'(r), 8'hFF);
    end
    reset = 1'b1;
    repeat (10) @(negedge clock);

    send(8'h1C);                 check("a_make", 4'd2, 8'hFB);
    send(8'hF0); send(8'h1C);    check("a_break", 4'd2, 8'hFF);

    send(8'hE0); send(8'h75);    check("up_make", 4'd9, 8'hFD);
    send(8'h75);                 check("kp8_unmapped", 4'd9, 8'hFD);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_break", 4'd9, 8'hFF);

    send(8'h12); send(8'h59);    check("shifts_make", 4'd0, 8'hFE);
    send(8'hF0); send(8'h12);    check("shift_last_break", 4'd0, 8'hFF);
    send(8'h59);                 check("rshift_make", 4'd0, 8'hFE);
    check("row12_held", 4'd12, 8'hFF);
    check("row15_held", 4'd15, 8'hFF);
    send(8'hF0); send(8'h59);    check("rshift_break", 4'd0, 8'hFF);

    send(8'h5A);                 check("enter_make", 4'd8, 8'hF7);
    send(8'hF0); send(8'h5A);    check("enter_break", 4'd8, 8'hFF);

    // A housekeeping byte between F0 and the code must keep the break pending.
    send(8'h1C);                 check("a_make2", 4'd2, 8'hFB);
    send(8'hF0); send(8'hAA); send(8'h1C);
    check("ignored_keeps_rel", 4'd2, 8'hFF);

    ps2_bits(frame(8'h1C, 1'b0), 5);
    repeat (2 * (6000 + 10) + 40) @(negedge clock);
    send(8'h29);                 check("space_after_timeout", 4'd1, 8'h7F);
    check("no_spurious_a", 4'd2, 8'hFF);
    send(8'hF0); send(8'h29);    check("space_break", 4'd1, 8'hFF);

    send(8'h07);
    exp_boots = 1;               check("boot_pulse", 4'd0, 8'hFF);
    send(8'hF0); send(8'h07);    check("boot_break_quiet", 4'd0, 8'hFF);
    send(8'h07);
    exp_boots = 2;               check("boot_repeat", 4'd0, 8'hFF);
    send(8'h78);
    exp_k = 1'b1;                check("kreset_make", 4'd0, 8'hFF);
    send(8'hF0); send(8'h78);
    exp_k = 1'b0;                check("kreset_break", 4'd0, 8'hFF);

    ps2_bits(frame(8'h1C, 1'b1), 11);
    repeat (40) @(negedge clock);
`ifdef PS2_PARITY_CHECK_EN
    check("bad_parity_dropped", 4'd2, 8'hFF);
`else
    check("bad_parity_ignored", 4'd2, 8'hFB);
    send(8'hF0); send(8'h1C);    check("a_break3", 4'd2, 8'hFF);
`endif

    send(8'h1C); send(8'h78);
    exp_k = 1'b1;                check("pre_reset_held", 4'd2, 8'hFB);
    ps2_bits(frame(8'h29, 1'b0), 6);
    reset = 1'b0;
    exp_k = 1'b0;                check("midframe_reset", 4'd2, 8'hFF);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    send(8'h1C);                 check("after_reset_a", 4'd2, 8'hFB);

    repeat (10) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
